// File: rtl/count_sseg_display.sv
// count_sseg_display
// Display stage behind the 7-bit counter. A change on count_in starts a
// sequential double-dabble conversion to three BCD digits. The last completed
// result is multiplexed onto a 4-digit common-anode seven-segment display.
// Anodes and segments are active-low.

module count_sseg_display #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_LEADING  = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [6:0]  count_in,
    output logic        conv_busy,
    output logic [11:0] bcd_out,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [18:0] dabble_step(input logic [18:0] s);
        logic [18:0] a;
        a = s;
        if (a[18:15] >= 4'd5) a[18:15] = a[18:15] + 4'd3;
        else                  a[18:15] = a[18:15];
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        else                  a[14:11] = a[14:11];
        if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7] + 4'd3;
        else                  a[10:7]  = a[10:7];
        return {a[17:0], 1'b0};
    endfunction

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes are dark.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    logic [0:0]       state_r,     state_n_s;
    logic [6:0]       last_val_r,  last_val_n_s;
    logic [18:0]      shift_r,     shift_n_s;
    logic [18:0]      shift_step_s;
    logic [2:0]       bit_cnt_r,   bit_cnt_n_s;
    logic [11:0]      bcd_r,       bcd_n_s;
    logic             busy_r,      busy_n_s;

    logic [CNT_W-1:0] refresh_cnt_r;
    logic [1:0]       digit_sel_r;
    logic [3:0]       an_r,  an_n_s;
    logic [6:0]       seg_r, seg_n_s;
    logic             dp_r;

    logic [3:0]       hund_s, tens_s, ones_s;
    logic             blank_h_s, blank_t_s;

    assign shift_step_s = dabble_step(shift_r);

    // Conversion FSM next-state: capture on a new count, then seven dabble steps.
    always_comb begin
        state_n_s    = state_r;
        last_val_n_s = last_val_r;
        shift_n_s    = shift_r;
        bit_cnt_n_s  = bit_cnt_r;
        bcd_n_s      = bcd_r;
        busy_n_s     = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (count_in != last_val_r) begin
                    state_n_s    = ST_CONV;
                    shift_n_s    = {12'd0, count_in};
                    last_val_n_s = count_in;
                    bit_cnt_n_s  = 3'd0;
                    busy_n_s     = 1'b1;
                end else begin
                    state_n_s    = ST_IDLE;
                end
            end
            ST_CONV: begin
                shift_n_s   = shift_step_s;
                bit_cnt_n_s = bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd6) begin
                    bcd_n_s   = shift_step_s[18:7];
                    state_n_s = ST_IDLE;
                    busy_n_s  = 1'b0;
                end else begin
                    state_n_s = ST_CONV;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                busy_n_s  = 1'b0;
            end
        endcase
    end

    // Conversion FSM registers; reset discards any conversion in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            last_val_r <= 7'd0;
            shift_r    <= 19'd0;
            bit_cnt_r  <= 3'd0;
            bcd_r      <= 12'd0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            last_val_r <= last_val_n_s;
            shift_r    <= shift_n_s;
            bit_cnt_r  <= bit_cnt_n_s;
            bcd_r      <= bcd_n_s;
            busy_r     <= busy_n_s;
        end
    end

    // Refresh timer: hold each digit slot REFRESH_CYCLES clocks, then advance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refresh_cnt_r <= '0;
            digit_sel_r   <= 2'd0;
        end else if (refresh_cnt_r == CNT_MAX) begin
            refresh_cnt_r <= '0;
            digit_sel_r   <= digit_sel_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + 1'b1;
            digit_sel_r   <= digit_sel_r;
        end
    end

    assign hund_s    = bcd_r[11:8];
    assign tens_s    = bcd_r[7:4];
    assign ones_s    = bcd_r[3:0];
    assign blank_h_s = (BLANK_LEADING != 0) && (hund_s == 4'd0);
    assign blank_t_s = blank_h_s && (tens_s == 4'd0);

    // Slot decode: pick the anode and segment pattern for the selected digit.
    always_comb begin
        an_n_s  = AN_OFF;
        seg_n_s = SEG_OFF;
        case (digit_sel_r)
            2'd0: begin
                an_n_s  = 4'b1110;
                seg_n_s = seg_code(ones_s);
            end
            2'd1: begin
                if (blank_t_s) begin
                    an_n_s  = AN_OFF;
                    seg_n_s = SEG_OFF;
                end else begin
                    an_n_s  = 4'b1101;
                    seg_n_s = seg_code(tens_s);
                end
            end
            2'd2: begin
                if (blank_h_s) begin
                    an_n_s  = AN_OFF;
                    seg_n_s = SEG_OFF;
                end else begin
                    an_n_s  = 4'b1011;
                    seg_n_s = seg_code(hund_s);
                end
            end
            2'd3: begin
                an_n_s  = AN_OFF;
                seg_n_s = SEG_OFF;
            end
            default: begin
                an_n_s  = AN_OFF;
                seg_n_s = SEG_OFF;
            end
        endcase
    end

    // Pin registers: glitch-free drive of the display; decimal point kept off.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_n_s;
            seg_r <= seg_n_s;
            dp_r  <= 1'b1;
        end
    end

    assign conv_busy = busy_r;
    assign bcd_out   = bcd_r;
    assign an        = an_r;
    assign seg       = seg_r;
    assign dp        = dp_r;

endmodule

// File: tb/tb_count_sseg_display.sv
// Bench for count_sseg_display: two instances (leading-zero blanking on/off)
// share inputs, are compared every cycle against an arithmetic model, and are
// also checked against hand-computed directed expectations.

module tb_count_sseg_display;

    localparam int R = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [6:0]  count_in = 7'd0;

    logic        busy_b, busy_s, dp_b, dp_s;
    logic [11:0] bcd_b, bcd_s;
    logic [3:0]  an_b, an_s;
    logic [6:0]  seg_b, seg_s;

    int n_pass  = 0;
    int n_total = 0;

    count_sseg_display #(.REFRESH_CYCLES(R), .BLANK_LEADING(1)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .count_in(count_in), .conv_busy(busy_b),
        .bcd_out(bcd_b), .an(an_b), .seg(seg_b), .dp(dp_b));

    count_sseg_display #(.REFRESH_CYCLES(R), .BLANK_LEADING(0)) u_dut_s (
        .CLK(CLK), .RST_N(RST_N), .count_in(count_in), .conv_busy(busy_s),
        .bcd_out(bcd_s), .an(an_s), .seg(seg_s), .dp(dp_s));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] digit_seg(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d >= 0 && d < 10) ? tab[d] : 7'b1111111;
    endfunction

    task automatic disp(input int slot, input logic [11:0] b, input bit blank,
                        output logic [3:0] a, output logic [6:0] s);
        int h, t, o, d;
        bit lit;
        h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
        lit = (slot == 0) || (slot == 1 && !(blank && h == 0 && t == 0)) ||
              (slot == 2 && !(blank && h == 0));
        d = (slot == 0) ? o : (slot == 1) ? t : h;
        a = lit ? ~(4'b0001 << slot) : 4'b1111;
        s = lit ? digit_seg(d) : 7'b1111111;
    endtask

    bit          m_busy;
    int          m_last, m_target, m_left, m_ticks;
    logic [11:0] m_bcd;
    logic [3:0]  m_an_b, m_an_s;
    logic [6:0]  m_seg_b, m_seg_s;

    // Model: conversion is a 7-edge countdown ending in v -> decimal digits;
    // the display shows slot (edge_index / R) % 4 of the value held before the edge.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy = 1'b0; m_last = 0; m_target = 0; m_left = 0; m_ticks = 0;
            m_bcd = 12'd0;
            m_an_b = 4'b1111; m_an_s = 4'b1111;
            m_seg_b = 7'b1111111; m_seg_s = 7'b1111111;
        end else begin
            disp((m_ticks / R) % 4, m_bcd, 1'b1, m_an_b, m_seg_b);
            disp((m_ticks / R) % 4, m_bcd, 1'b0, m_an_s, m_seg_s);
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd  = to_bcd(m_target);
                    m_busy = 1'b0;
                end
            end else if (int'(count_in) != m_last) begin
                m_last   = int'(count_in);
                m_target = int'(count_in);
                m_left   = 7;
                m_busy   = 1'b1;
            end
            m_ticks++;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        chk("busy_b", 32'(busy_b), 32'(m_busy));
        chk("bcd_b",  32'(bcd_b),  32'(m_bcd));
        chk("an_b",   32'(an_b),   32'(m_an_b));
        chk("seg_b",  32'(seg_b),  32'(m_seg_b));
        chk("dp_b",   32'(dp_b),   32'd1);
        chk("bcd_s",  32'(bcd_s),  32'(m_bcd));
        chk("an_s",   32'(an_s),   32'(m_an_s));
        chk("seg_s",  32'(seg_s),  32'(m_seg_s));
    end

    // ---------------- directed tests ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    // Lock onto the start of slot 0 (dark -> ones lit) and check 16 cycles.
    task automatic scan_check(input string name, input bit sel,
                              input logic [15:0] exp_an, input logic [27:0] exp_seg);
        logic [3:0] prev, cur;
        bit found;
        int slot;
        prev = 4'h0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            cur = sel ? an_b : an_s;
            if (prev == 4'hF && cur == 4'hE) found = 1'b1;
            prev = cur;
        end
        chk({name, " sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                slot = k / 4;
                chk({name, " an"},  32'(sel ? an_b : an_s),   32'(exp_an[4*slot +: 4]));
                chk({name, " seg"}, 32'(sel ? seg_b : seg_s), 32'(exp_seg[7*slot +: 7]));
                tick(1);
            end
        end
    endtask

    initial begin
        // 1: reset, then async reset between edges, then idle with count 0
        tick(2);
        RST_N = 1'b1;
        tick(3);
        chk("pre-reset an", 32'(an_b), 32'h0000000E);
        #2 RST_N = 1'b0;
        #1;
        chk("rst an",   32'(an_b),   32'h0000000F);
        chk("rst seg",  32'(seg_b),  32'h0000007F);
        chk("rst bcd",  32'(bcd_b),  32'h00000000);
        chk("rst busy", 32'(busy_b), 32'h00000000);
        @(negedge CLK) RST_N = 1'b1;
        tick(10);
        chk("idle busy", 32'(busy_b), 32'h00000000);
        chk("idle bcd",  32'(bcd_b),  32'h00000000);

        // 2: 0 -> 10, latency
        count_in = 7'd10;
        tick(2);
        chk("t2 busy N+1", 32'(busy_b), 32'h00000001);
        tick(5);
        chk("t2 busy N+6", 32'(busy_b), 32'h00000001);
        chk("t2 bcd N+6",  32'(bcd_b),  32'h00000000);
        tick(1);
        chk("t2 bcd N+7",  32'(bcd_b),  32'h00000010);
        chk("t2 busy N+7", 32'(busy_b), 32'h00000000);

        // 3: 127 full scan
        count_in = 7'd127;
        tick(9);
        chk("t3 bcd", 32'(bcd_b), 32'h00000127);
        scan_check("t3 scan", 1'b1, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1111111, 7'b1111001, 7'b0100100, 7'b1111000});

        // 4: 5 with and without blanking
        count_in = 7'd5;
        tick(9);
        chk("t4 bcd", 32'(bcd_b), 32'h00000005);
        scan_check("t4 blank", 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110},
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010});
        scan_check("t4 show", 1'b0, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                   {7'b1111111, 7'b1000000, 7'b1000000, 7'b0010010});

        // 5: 20 then 60 during the conversion
        count_in = 7'd20;
        tick(2);
        count_in = 7'd60;
        tick(6);
        chk("t5 bcd N+7",   32'(bcd_b),  32'h00000020);
        chk("t5 busy N+7",  32'(busy_b), 32'h00000000);
        tick(1);
        chk("t5 busy N+8",  32'(busy_b), 32'h00000001);
        tick(6);
        chk("t5 bcd N+14",  32'(bcd_b),  32'h00000020);
        tick(1);
        chk("t5 bcd N+15",  32'(bcd_b),  32'h00000060);

        // 6: reset in the 3rd conversion cycle of 60
        count_in = 7'd100;
        tick(8);
        chk("t6 bcd 100", 32'(bcd_b), 32'h00000100);
        count_in = 7'd60;
        tick(3);
        chk("t6 busy mid", 32'(busy_b), 32'h00000001);
        #2 RST_N = 1'b0;
        #1;
        chk("t6 rst bcd",  32'(bcd_b),  32'h00000000);
        chk("t6 rst busy", 32'(busy_b), 32'h00000000);
        chk("t6 rst an",   32'(an_b),   32'h0000000F);
        @(negedge CLK) RST_N = 1'b1;
        #1;
        tick(1);
        chk("t6 busy M",   32'(busy_b), 32'h00000001);
        tick(6);
        chk("t6 bcd M+6",  32'(bcd_b),  32'h00000000);
        tick(1);
        chk("t6 bcd M+7",  32'(bcd_b),  32'h00000060);
        chk("t6 busy M+7", 32'(busy_b), 32'h00000000);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
